pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM receiver paired with the team's counter/comparator PWM generator. It samples an asynchronous PWM input and measures, per period (rising edge to rising edge), the number of high cycles and the total period length. It reports each measurement with a one-cycle valid pulse and flags an input stuck at a constant level. It sits on the input side of a PWM link, e.g. for loop-back checking of the generator or for decoding an external duty-cycle signal.

## Interface
- PWD_WIDTH, 4, duty width W; matches the generator's PWD_WIDTH. DMAX = 2^W−1, PMAX = 2^(W+1)−1.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pwm_in  input  1  PWM signal, asynchronous to clk.
- duty  output  W  high-cycle count of last measured period, saturated at DMAX.
- period  output  W+1  cycle count of last measured period, saturated at PMAX.
- valid  output  1  one-cycle pulse: duty/period/stuck just updated.
- stuck  output  1  last report was a constant-level timeout, not a real period.

## Operation
- Synchronizer: two flops give pwm_s. A third flop holds pwm_d, the previous pwm_s. A rise is detected when pwm_s & ~pwm_d.
- Internal counters:
  - per_cnt, W+1 bits, saturating.
  - hi_cnt, W+1 bits, saturating.
  - armed, 1 bit.
- Rise cycle has top priority:
  - If armed: duty <= min(hi_cnt, DMAX), period <= per_cnt, stuck <= 0, valid <= 1.
  - If not armed: no report, and armed <= 1.
  - In both cases per_cnt <= 1 and hi_cnt <= 1. This cycle counts as the first high cycle of the new period.
- Timeout (no rise and per_cnt == PMAX):
  - Report duty <= (pwm_s ? DMAX : 0), period <= PMAX, stuck <= 1, valid <= 1.
  - Then per_cnt <= 1, hi_cnt <= pwm_s, armed <= 0. The next rise starts a fresh measurement without reporting.
- Otherwise: per_cnt <= per_cnt+1, hi_cnt <= hi_cnt + pwm_s. Both saturate at PMAX.
- duty, period and stuck hold their values between reports.
- Consistency with the generator: input imp=k (0 < k < 2^W) produces a report of duty=k, period=2^W. imp=0 produces stuck=1, duty=0.

## Timing
- Reset values: duty=0, period=0, valid=0, stuck=0. Also per_cnt=0, hi_cnt=0, armed=0, and all synchronizer flops 0.
- Reset mid-operation clears everything immediately, since the reset is asynchronous. The partial period in progress is discarded. The first rise after release only arms the block.
- Latency: pwm_in rise sampled at edge k → pwm_s high after edge k+1 → outputs and valid registered at edge k+2. valid is high for exactly one cycle.
- Minimum measurable: period 2 cycles (1 high, 1 low). Pulses shorter than one clock may be missed. This is not an error condition.
- Constant input: the first stuck report comes ≤ PMAX+3 cycles after reset release. Reports then repeat every PMAX cycles while the level holds.
- A rise in the same cycle as per_cnt == PMAX is treated as a rise, with no stuck report.

## Structure
- Shared package pwm_pkg holds PWD_WIDTH_DEFAULT = 4. Both the generator and this block use it. DMAX and PMAX are local constants derived from PWD_WIDTH.
- One sub-module: sync_edge. It contains the 2-flop synchronizer plus pwm_d, and outputs pwm_s and rise. It is reusable for other async inputs.
- Measurement counters, arm logic and output registers live in pwm_capture.

## Test plan
- Generator loop-back, W=4, imp=5:
  - The first complete period after reset produces no report.
  - Every following 16 cycles: valid, duty=5, period=16, stuck=0.
- imp=15 (high 15, low 1): duty=15, period=16. Then switch to imp=1: the first report after the switch spans the transition period, and subsequent reports are duty=1, period=16.
- pwm_in held low from reset: valid with stuck=1, duty=0, period=31, repeating every 31 cycles. Then apply imp=8: first rise gives no report, next rise gives duty=8, period=16, stuck=0.
- pwm_in held high: stuck=1, duty=15, period=31 every 31 cycles.
- Long high, 40 cycles high then 4 low, repeating: the timeout fires with stuck=1, duty=15 during the high. Later periods report stuck=1, showing that the stuck/re-arm behaviour occurs instead of a saturated real period.
- Reset pulse asserted mid-period: outputs return to 0 with no clock edge needed. After release, no valid until the second rise. The next report is correct (duty=5, period=16 with imp=5).

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM generator / capture pair.
//   PWD_WIDTH_DEFAULT : default duty width W used by both ends of the link.
//   meas_event_t      : what the capture block does on a given clock cycle.
package pwm_pkg;

   localparam int PWD_WIDTH_DEFAULT = 4;

   // Per-cycle measurement event. A rise always wins over a timeout.
   typedef enum logic [1:0] {
      EV_NONE    = 2'd0,
      EV_RISE    = 2'd1,
      EV_TIMEOUT = 2'd2
   } meas_event_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Two-flop synchronizer for an asynchronous single-bit input, plus one extra
// flop holding the previous synchronized value for rising-edge detection.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset, clears all flops to 0
//   in_async : asynchronous input
//   in_s     : synchronized input (second synchronizer stage)
//   rise     : combinational, high while in_s is 1 and its previous value was 0
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic in_async,
   output logic in_s,
   output logic rise
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
         prev_reg <= 1'b0;
      end else begin
         meta_reg <= in_async;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign in_s = sync_reg;
   assign rise = sync_reg & ~prev_reg;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
// PWM receiver: measures high-cycle count and period length of an asynchronous
// PWM input, rising edge to rising edge, and flags a constant-level input.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   pwm_in : PWM input, asynchronous to clk
//   duty   : high cycles of last measured period, saturated at DMAX
//   period : cycles of last measured period, saturated at PMAX
//   valid  : one-cycle pulse, duty/period/stuck just updated
//   stuck  : last report was a constant-level timeout
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int PWD_WIDTH = PWD_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pwm_in,
   output logic [PWD_WIDTH-1:0] duty,
   output logic [PWD_WIDTH:0]   period,
   output logic                 valid,
   output logic                 stuck
);

   localparam int W = PWD_WIDTH;
   localparam logic [W-1:0] DMAX    = {W{1'b1}};
   localparam logic [W:0]   PMAX    = {(W+1){1'b1}};
   localparam logic [W:0]   CNT_ONE = {{W{1'b0}}, 1'b1};

   logic pwm_s;
   logic rise;

   sync_edge u_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_async (pwm_in),
      .in_s     (pwm_s),
      .rise     (rise)
   );

   logic [W:0]   per_cnt_reg, per_cnt_next;
   logic [W:0]   hi_cnt_reg,  hi_cnt_next;
   logic         armed_reg,   armed_next;
   logic [W-1:0] duty_reg,    duty_next;
   logic [W:0]   period_reg,  period_next;
   logic         stuck_reg,   stuck_next;
   logic         valid_reg,   valid_next;

   meas_event_t  ev;
   logic [W-1:0] hi_clamped;

   // hi_cnt can exceed DMAX when the high phase is longer than the duty
   // range; report the clamped value.
   assign hi_clamped = (hi_cnt_reg > {1'b0, DMAX}) ? DMAX : hi_cnt_reg[W-1:0];

   always_comb begin
      ev = EV_NONE;
      if (rise) begin
         ev = EV_RISE;
      end else if (per_cnt_reg == PMAX) begin
         ev = EV_TIMEOUT;
      end
   end

   always_comb begin
      per_cnt_next = per_cnt_reg;
      hi_cnt_next  = hi_cnt_reg;
      armed_next   = armed_reg;
      duty_next    = duty_reg;
      period_next  = period_reg;
      stuck_next   = stuck_reg;
      valid_next   = 1'b0;

      case (ev)
         EV_RISE: begin
            // The first rise after reset or a timeout only starts a
            // measurement; there is no complete period to report yet.
            if (armed_reg) begin
               duty_next   = hi_clamped;
               period_next = per_cnt_reg;
               stuck_next  = 1'b0;
               valid_next  = 1'b1;
            end else begin
               armed_next  = 1'b1;
            end
            // The rise cycle itself is the first high cycle of the new period.
            per_cnt_next = CNT_ONE;
            hi_cnt_next  = CNT_ONE;
         end
         EV_TIMEOUT: begin
            duty_next    = pwm_s ? DMAX : '0;
            period_next  = PMAX;
            stuck_next   = 1'b1;
            valid_next   = 1'b1;
            per_cnt_next = CNT_ONE;
            hi_cnt_next  = {{W{1'b0}}, pwm_s};
            // A period that spanned a timeout is not trustworthy.
            armed_next   = 1'b0;
         end
         default: begin
            per_cnt_next = (per_cnt_reg == PMAX) ? PMAX : per_cnt_reg + CNT_ONE;
            hi_cnt_next  = (hi_cnt_reg == PMAX) ? PMAX
                         : hi_cnt_reg + {{W{1'b0}}, pwm_s};
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt_reg <= '0;
         hi_cnt_reg  <= '0;
         armed_reg   <= 1'b0;
         duty_reg    <= '0;
         period_reg  <= '0;
         stuck_reg   <= 1'b0;
         valid_reg   <= 1'b0;
      end else begin
         per_cnt_reg <= per_cnt_next;
         hi_cnt_reg  <= hi_cnt_next;
         armed_reg   <= armed_next;
         duty_reg    <= duty_next;
         period_reg  <= period_next;
         stuck_reg   <= stuck_next;
         valid_reg   <= valid_next;
      end
   end

   assign duty   = duty_reg;
   assign period = period_reg;
   assign valid  = valid_reg;
   assign stuck  = stuck_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Directed bench for pwm_capture with W=4 (DMAX=15, PMAX=31). Stimulus tasks
// shape pwm_in cycle by cycle; a negedge monitor records every valid report
// with its cycle stamp, and each scenario task checks the recorded reports.
module tb_pwm_capture;

   logic       clk;
   logic       rst_n;
   logic       pwm_in;
   logic [3:0] duty;
   logic [4:0] period;
   logic       valid;
   logic       stuck;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rel_cyc  = 0;
   int dbl_cnt  = 0;
   logic valid_prev = 1'b0;

   typedef struct {
      logic [3:0] duty;
      logic [4:0] period;
      logic       stuck;
      int         cyc;
   } rpt_t;

   rpt_t q[$];

   pwm_capture #(.PWD_WIDTH(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .duty   (duty),
      .period (period),
      .valid  (valid),
      .stuck  (stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         q.push_back('{duty: duty, period: period, stuck: stuck, cyc: cyc});
         if (valid_prev) dbl_cnt <= dbl_cnt + 1;
      end
      valid_prev <= valid;
   end

   // Hold pwm_in at lvl across exactly one rising clock edge.
   task automatic step(input logic lvl);
      pwm_in = lvl;
      @(posedge clk);
      #1;
   endtask

   task automatic run_pwm(input int hi, input int lo, input int n);
      for (int p = 0; p < n; p++) begin
         repeat (hi) step(1'b1);
         repeat (lo) step(1'b0);
      end
   endtask

   task automatic apply_reset();
      pwm_in = 1'b0;
      rst_n  = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n   = 1'b1;
      rel_cyc = cyc;
      q.delete();
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (duty !== 4'd0)   begin n_fail++; $display("FAIL reset_duty: got %0d want 0", duty); end
      n_checks++; if (period !== 5'd0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period); end
      n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
      n_checks++; if (stuck !== 1'b0)  begin n_fail++; $display("FAIL reset_stuck: got %0b want 0", stuck); end
      $display("test_reset: outputs duty=%0d period=%0d valid=%0b stuck=%0b", duty, period, valid, stuck);
   endtask

   // imp=5: five periods; first rise only arms, rises 2..5 report.
   task automatic test_loopback();
      apply_reset();
      run_pwm(5, 11, 5);
      repeat (3) step(1'b0);
      n_checks++; if (q.size() !== 4) begin n_fail++; $display("FAIL loop_count: got %0d want 4", q.size()); end
      for (int i = 0; i < q.size(); i++) begin
         $display("test_loopback: report %0d duty=%0d period=%0d stuck=%0b", i, q[i].duty, q[i].period, q[i].stuck);
         n_checks++;
         if (q[i].duty !== 4'd5 || q[i].period !== 5'd16 || q[i].stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_report%0d: got %0d/%0d/%0b want 5/16/0", i, q[i].duty, q[i].period, q[i].stuck);
         end
      end
      // Rise of period 2 is sampled at edge 17, registered two edges later.
      if (q.size() > 0) begin
         n_checks++; if (q[0].cyc - rel_cyc !== 19) begin n_fail++; $display("FAIL loop_latency: got %0d want 19", q[0].cyc - rel_cyc); end
      end
      for (int i = 1; i < q.size(); i++) begin
         n_checks++; if (q[i].cyc - q[i-1].cyc !== 16) begin n_fail++; $display("FAIL loop_spacing%0d: got %0d want 16", i, q[i].cyc - q[i-1].cyc); end
      end
   endtask

   // imp=15 for three periods, then imp=1 for three periods.
   task automatic test_duty_switch();
      logic [3:0] exp_duty [5];
      exp_duty = '{4'd15, 4'd15, 4'd15, 4'd1, 4'd1};
      apply_reset();
      run_pwm(15, 1, 3);
      run_pwm(1, 15, 3);
      repeat (3) step(1'b0);
      n_checks++; if (q.size() !== 5) begin n_fail++; $display("FAIL switch_count: got %0d want 5", q.size()); end
      for (int i = 0; i < q.size() && i < 5; i++) begin
         $display("test_duty_switch: report %0d duty=%0d period=%0d stuck=%0b", i, q[i].duty, q[i].period, q[i].stuck);
         n_checks++;
         if (q[i].duty !== exp_duty[i] || q[i].period !== 5'd16 || q[i].stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_report%0d: got %0d/%0d/%0b want %0d/16/0", i, q[i].duty, q[i].period, q[i].stuck, exp_duty[i]);
         end
      end
   endtask

   // Constant low from reset, then imp=8.
   task automatic test_stuck_low();
      apply_reset();
      repeat (100) step(1'b0);
      n_checks++; if (q.size() !== 3) begin n_fail++; $display("FAIL stlow_count: got %0d want 3", q.size()); end
      if (q.size() > 0) begin
         n_checks++;
         if (q[0].cyc - rel_cyc > 34) begin n_fail++; $display("FAIL stlow_first: got %0d cycles want <=34", q[0].cyc - rel_cyc); end
      end
      for (int i = 0; i < q.size(); i++) begin
         $display("test_stuck_low: report %0d duty=%0d period=%0d stuck=%0b", i, q[i].duty, q[i].period, q[i].stuck);
         n_checks++;
         if (q[i].duty !== 4'd0 || q[i].period !== 5'd31 || q[i].stuck !== 1'b1) begin
            n_fail++;
            $display("FAIL stlow_report%0d: got %0d/%0d/%0b want 0/31/1", i, q[i].duty, q[i].period, q[i].stuck);
         end
         if (i > 0) begin
            n_checks++;
            if (q[i].cyc - q[i-1].cyc !== 31) begin n_fail++; $display("FAIL stlow_spacing%0d: got %0d want 31", i, q[i].cyc - q[i-1].cyc); end
         end
      end
      q.delete();
      run_pwm(8, 8, 3);
      n_checks++; if (q.size() !== 2) begin n_fail++; $display("FAIL rearm_count: got %0d want 2", q.size()); end
      for (int i = 0; i < q.size(); i++) begin
         $display("test_stuck_low: rearm report %0d duty=%0d period=%0d stuck=%0b", i, q[i].duty, q[i].period, q[i].stuck);
         n_checks++;
         if (q[i].duty !== 4'd8 || q[i].period !== 5'd16 || q[i].stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_report%0d: got %0d/%0d/%0b want 8/16/0", i, q[i].duty, q[i].period, q[i].stuck);
         end
      end
   endtask

   // Constant high: rise arms at edge 3, timeouts at edges 34, 65, 96.
   task automatic test_stuck_high();
      apply_reset();
      repeat (100) step(1'b1);
      n_checks++; if (q.size() !== 3) begin n_fail++; $display("FAIL sthigh_count: got %0d want 3", q.size()); end
      for (int i = 0; i < q.size(); i++) begin
         $display("test_stuck_high: report %0d duty=%0d period=%0d stuck=%0b", i, q[i].duty, q[i].period, q[i].stuck);
         n_checks++;
         if (q[i].duty !== 4'd15 || q[i].period !== 5'd31 || q[i].stuck !== 1'b1) begin
            n_fail++;
            $display("FAIL sthigh_report%0d: got %0d/%0d/%0b want 15/31/1", i, q[i].duty, q[i].period, q[i].stuck);
         end
         if (i > 0) begin
            n_checks++;
            if (q[i].cyc - q[i-1].cyc !== 31) begin n_fail++; $display("FAIL sthigh_spacing%0d: got %0d want 31", i, q[i].cyc - q[i-1].cyc); end
         end
      end
      step(1'b0);
   endtask

   // 40 high / 4 low: each period times out during the high phase and the
   // following rise only re-arms, so every report is a stuck-high one.
   task automatic test_long_high();
      apply_reset();
      run_pwm(40, 4, 3);
      repeat (3) step(1'b0);
      n_checks++; if (q.size() !== 3) begin n_fail++; $display("FAIL long_count: got %0d want 3", q.size()); end
      for (int i = 0; i < q.size(); i++) begin
         $display("test_long_high: report %0d duty=%0d period=%0d stuck=%0b", i, q[i].duty, q[i].period, q[i].stuck);
         n_checks++;
         if (q[i].duty !== 4'd15 || q[i].period !== 5'd31 || q[i].stuck !== 1'b1) begin
            n_fail++;
            $display("FAIL long_report%0d: got %0d/%0d/%0b want 15/31/1", i, q[i].duty, q[i].period, q[i].stuck);
         end
      end
   endtask

   // 31-cycle period: the rise lands on per_cnt == PMAX and must win over the
   // timeout; the 20-cycle high phase also exercises duty clamping.
   task automatic test_rise_at_pmax();
      apply_reset();
      run_pwm(20, 11, 3);
      repeat (3) step(1'b0);
      n_checks++; if (q.size() !== 2) begin n_fail++; $display("FAIL pmax_count: got %0d want 2", q.size()); end
      for (int i = 0; i < q.size(); i++) begin
         $display("test_rise_at_pmax: report %0d duty=%0d period=%0d stuck=%0b", i, q[i].duty, q[i].period, q[i].stuck);
         n_checks++;
         if (q[i].duty !== 4'd15 || q[i].period !== 5'd31 || q[i].stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL pmax_report%0d: got %0d/%0d/%0b want 15/31/0", i, q[i].duty, q[i].period, q[i].stuck);
         end
      end
   endtask

   // Minimum period: 1 high, 1 low, reports every 2 cycles.
   task automatic test_back_to_back();
      apply_reset();
      run_pwm(1, 1, 6);
      repeat (3) step(1'b0);
      n_checks++; if (q.size() !== 5) begin n_fail++; $display("FAIL b2b_count: got %0d want 5", q.size()); end
      for (int i = 0; i < q.size(); i++) begin
         $display("test_back_to_back: report %0d duty=%0d period=%0d stuck=%0b", i, q[i].duty, q[i].period, q[i].stuck);
         n_checks++;
         if (q[i].duty !== 4'd1 || q[i].period !== 5'd2 || q[i].stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_report%0d: got %0d/%0d/%0b want 1/2/0", i, q[i].duty, q[i].period, q[i].stuck);
         end
         if (i > 0) begin
            n_checks++;
            if (q[i].cyc - q[i-1].cyc !== 2) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 2", i, q[i].cyc - q[i-1].cyc); end
         end
      end
   endtask

   // Asynchronous reset in the middle of a high phase.
   task automatic test_reset_mid();
      apply_reset();
      run_pwm(5, 11, 2);
      repeat (3) step(1'b1);
      n_checks++; if (duty !== 4'd5) begin n_fail++; $display("FAIL mid_before_duty: got %0d want 5", duty); end
      rst_n = 1'b0;
      #2;
      $display("test_reset_mid: during reset duty=%0d period=%0d valid=%0b stuck=%0b", duty, period, valid, stuck);
      n_checks++; if (duty !== 4'd0)   begin n_fail++; $display("FAIL mid_duty: got %0d want 0", duty); end
      n_checks++; if (period !== 5'd0) begin n_fail++; $display("FAIL mid_period: got %0d want 0", period); end
      n_checks++; if (stuck !== 1'b0)  begin n_fail++; $display("FAIL mid_stuck: got %0b want 0", stuck); end
      pwm_in = 1'b0;
      @(posedge clk); #1;
      rst_n   = 1'b1;
      rel_cyc = cyc;
      q.delete();
      repeat (3) step(1'b0);
      run_pwm(5, 11, 3);
      repeat (3) step(1'b0);
      n_checks++; if (q.size() !== 2) begin n_fail++; $display("FAIL mid_count: got %0d want 2", q.size()); end
      // Second rise: pwm_in high at step 20, reported at edge 22.
      if (q.size() > 0) begin
         n_checks++; if (q[0].cyc - rel_cyc !== 22) begin n_fail++; $display("FAIL mid_first_cyc: got %0d want 22", q[0].cyc - rel_cyc); end
      end
      for (int i = 0; i < q.size(); i++) begin
         $display("test_reset_mid: report %0d duty=%0d period=%0d stuck=%0b", i, q[i].duty, q[i].period, q[i].stuck);
         n_checks++;
         if (q[i].duty !== 4'd5 || q[i].period !== 5'd16 || q[i].stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_report%0d: got %0d/%0d/%0b want 5/16/0", i, q[i].duty, q[i].period, q[i].stuck);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_duty_switch();
      test_stuck_low();
      test_stuck_high();
      test_long_high();
      test_rise_at_pmax();
      test_back_to_back();
      test_reset_mid();
      n_checks++;
      if (dbl_cnt !== 0) begin n_fail++; $display("FAIL valid_width: got %0d multi-cycle pulses want 0", dbl_cnt); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
